// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetcher, the instruction queue and decode.
// The master side is the fetcher/decode pair; the slave side is the queue.
interface fetch_queue_if #(
  parameter int bits  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [bits-1:0] in_pc;
  logic [bits-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [bits-1:0] out_pc;
  logic [bits-1:0] out_instr;
  logic [CW-1:0]   count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: buffers {pc, instr} pairs,
// back-pressures the fetcher, shows a NOP when empty and clears on redirect.
module fetch_queue #(
  parameter int              bits  = 32,
  parameter int              DEPTH = 4,
  parameter logic [bits-1:0] NOP   = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*bits-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              full;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic [2*bits-1:0] head;

  // Readiness looks only at occupancy, so a full queue never admits a push
  // even when decode drains the head in the same cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = q.in_valid & ~full & ~q.flush;
  assign pop       = not_empty & q.out_ready & ~q.flush;
  assign head      = mem[rd_ptr];

  assign q.in_ready  = ~full;
  assign q.out_valid = not_empty;
  assign q.count     = count_q;
  assign q.out_pc    = not_empty ? head[2*bits-1:bits] : '0;
  assign q.out_instr = not_empty ? head[bits-1:0]      : NOP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {q.in_pc, q.in_instr};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven cycle vectors plus a
// reference queue that predicts every output and the order of emerging entries.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.bits(32), .DEPTH(DEPTH)) fq ();

  fetch_queue #(.bits(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .q   (fq.slave)
  );

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        out_ready;
    int          exp_count;
  } vec_t;

  vec_t        vecs [$];
  logic [63:0] sb [$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drives one cycle, checks outputs against
  // the reference queue, then advances the model across the next edge.
  task automatic step(input logic f, input logic iv, input logic [31:0] pc,
                      input logic [31:0] ins, input logic ordy, output logic acc);
    logic exp_rdy, exp_ov, push_m, pop_m;
    fq.flush     = f;
    fq.in_valid  = iv;
    fq.in_pc     = pc;
    fq.in_instr  = ins;
    fq.out_ready = ordy;
    #1;
    exp_rdy = (sb.size() != DEPTH);
    exp_ov  = (sb.size() != 0);
    chk("in_ready",  64'(fq.in_ready),  64'(exp_rdy));
    chk("out_valid", 64'(fq.out_valid), 64'(exp_ov));
    chk("count",     64'(fq.count),     64'(sb.size()));
    if (exp_ov) begin
      chk("out_pc",    64'(fq.out_pc),    64'(sb[0][63:32]));
      chk("out_instr", 64'(fq.out_instr), 64'(sb[0][31:0]));
    end else begin
      chk("out_pc_empty",    64'(fq.out_pc),    64'(0));
      chk("out_instr_empty", 64'(fq.out_instr), 64'(NOP));
    end
    push_m = iv & exp_rdy & ~f;
    pop_m  = exp_ov & ordy & ~f;
    if (f) sb.delete();
    else begin
      if (pop_m)  void'(sb.pop_front());
      if (push_m) sb.push_back({pc, ins});
    end
    acc = push_m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] instrs [10];
    int          idx, cyc;
    logic        did_rst;

    fq.flush = 1'b0; fq.in_valid = 1'b0; fq.in_pc = '0; fq.in_instr = '0; fq.out_ready = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(fq.out_valid), 64'(0));
    chk("rst_in_ready",  64'(fq.in_ready),  64'(1));
    chk("rst_count",     64'(fq.count),     64'(0));
    chk("rst_out_instr", 64'(fq.out_instr), 64'h13);
    chk("rst_out_pc",    64'(fq.out_pc),    64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    vecs.push_back('{0, 1, 32'hBEEFBEEF, 32'hCAFECAFE, 0, 1});
    vecs.push_back('{0, 1, 32'h0000_0004, 32'hA0000001, 0, 2});
    vecs.push_back('{0, 1, 32'h0000_0008, 32'hA0000002, 0, 3});
    vecs.push_back('{0, 1, 32'h0000_000C, 32'hA0000003, 0, 4});
    vecs.push_back('{0, 1, 32'h0000_0099, 32'hFAFAFAFA, 0, 4});
    vecs.push_back('{0, 1, 32'h0000_0099, 32'hFAFAFAFA, 0, 4});
    vecs.push_back('{0, 1, 32'h0000_0099, 32'hFAFAFAFA, 1, 3});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h00000000, 1, 2});
    vecs.push_back('{0, 1, 32'h0000_0010, 32'h11111111, 1, 2});
    vecs.push_back('{0, 1, 32'h0000_0014, 32'h22222222, 1, 2});
    vecs.push_back('{0, 1, 32'h0000_0018, 32'h33333333, 0, 3});
    vecs.push_back('{1, 1, 32'h0000_001C, 32'h44444444, 1, 0});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h00000000, 1, 0});
    vecs.push_back('{0, 1, 32'h0000_0020, 32'h55555555, 0, 1});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h00000000, 1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].flush, vecs[i].in_valid, vecs[i].pc, vecs[i].instr, vecs[i].out_ready, acc);
      chk($sformatf("vec%0d_count", i), 64'(fq.count), 64'(vecs[i].exp_count));
    end
    chk("post_flush_instr", 64'(fq.out_instr), 64'(NOP));

    // Stream ten instructions with random decode stalls; reset mid-stream
    for (int i = 0; i < 10; i++) instrs[i] = $urandom;
    idx = 0; cyc = 0; did_rst = 1'b0;
    while (idx < 10 && cyc < 300) begin
      step(1'b0, 1'b1, 32'(idx * 4), instrs[idx], 1'($urandom_range(0, 1)), acc);
      cyc++;
      if (acc) idx++;
      if (idx == 6 && !did_rst) begin
        did_rst = 1'b1;
        fq.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_count",     64'(fq.count),     64'(0));
        chk("midrst_out_valid", 64'(fq.out_valid), 64'(0));
        chk("midrst_in_ready",  64'(fq.in_ready),  64'(1));
        chk("midrst_out_instr", 64'(fq.out_instr), 64'(NOP));
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    while (sb.size() != 0 && cyc < 300) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
      cyc++;
    end
    if (cyc >= 300) chk("stream_timeout", 64'(cyc), 64'(0));
    chk("stream_reset_seen", 64'(did_rst), 64'(1));
    chk("final_count", 64'(fq.count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
